// File: rtl/mul_seq_ctrl_if.sv
// rtl/mul_seq_ctrl_if.sv - pipeline and multiplier datapath signals of the HI/LO multiply sequencer
interface mul_seq_ctrl_if #(
    parameter int WIDTH = 16
);
    logic               op_valid;
    logic               op_signed;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic               wr_hi;
    logic               wr_lo;
    logic [WIDTH-1:0]   wr_data;
    logic               rd_hi;
    logic               rd_lo;
    logic               op_ready;
    logic               stall;
    logic               done;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic [WIDTH-1:0]   mul_mcand;
    logic [WIDTH-1:0]   mul_mplier;
    logic               mul_start;
    logic [2*WIDTH-1:0] mul_product;

    // master: pipeline plus multiplier datapath; slave: the sequencer
    modport master (
        output op_valid, op_signed, op_a, op_b, wr_hi, wr_lo, wr_data, rd_hi, rd_lo, mul_product,
        input  op_ready, stall, done, hi, lo, mul_mcand, mul_mplier, mul_start
    );

    modport slave (
        input  op_valid, op_signed, op_a, op_b, wr_hi, wr_lo, wr_data, rd_hi, rd_lo, mul_product,
        output op_ready, stall, done, hi, lo, mul_mcand, mul_mplier, mul_start
    );
endinterface

// File: rtl/mul_seq_ctrl.sv
// rtl/mul_seq_ctrl.sv - MULT/MULTU/MFHI/MFLO/MTHI/MTLO sequencer around a shift-add multiplier
module mul_seq_ctrl #(
    parameter int WIDTH      = 16,
    parameter int MUL_CYCLES = 2 * WIDTH
) (
    input  logic           clk,
    input  logic           rst_n,
    mul_seq_ctrl_if.slave  bus
);
    localparam int CNT_W = (MUL_CYCLES > 2) ? $clog2(MUL_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        FIX   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               start_q, start_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [2*WIDTH-1:0] fixed_product;
    logic               busy;

    // 0x8000 negates to itself, which is exactly 2^(WIDTH-1) read as unsigned
    always_comb begin
        abs_a = (bus.op_signed && bus.op_a[WIDTH-1]) ? (~bus.op_a + WIDTH'(1)) : bus.op_a;
        abs_b = (bus.op_signed && bus.op_b[WIDTH-1]) ? (~bus.op_b + WIDTH'(1)) : bus.op_b;
        fixed_product = neg_q ? (~bus.mul_product + (2*WIDTH)'(1)) : bus.mul_product;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        neg_d    = neg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        start_d  = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.wr_hi) hi_d = bus.wr_data;
                if (bus.wr_lo) lo_d = bus.wr_data;
                if (bus.op_valid) begin
                    mcand_d  = abs_a;
                    mplier_d = abs_b;
                    neg_d    = bus.op_signed & (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
                    start_d  = 1'b1;
                    state_d  = START;
                end
            end
            START: begin
                cnt_d   = CNT_W'(MUL_CYCLES - 1);
                state_d = RUN;
            end
            RUN: begin
                if (cnt_q == '0) state_d = FIX;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            FIX: begin
                {hi_d, lo_d} = fixed_product;
                done_d       = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            start_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            start_q  <= start_d;
            done_q   <= done_d;
        end
    end

    // any HI/LO touch or new issue must wait until the result has landed
    assign busy           = (state_q != IDLE);
    assign bus.op_ready   = ~busy;
    assign bus.stall      = busy & (bus.op_valid | bus.rd_hi | bus.rd_lo | bus.wr_hi | bus.wr_lo);
    assign bus.done       = done_q;
    assign bus.hi         = hi_q;
    assign bus.lo         = lo_q;
    assign bus.mul_mcand  = mcand_q;
    assign bus.mul_mplier = mplier_q;
    assign bus.mul_start  = start_q;
endmodule

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
- Sequencer between the CPU pipeline and the shared shift-add multiplier datapath; implements MULT/MULTU/MFHI/MFLO/MTHI/MTLO.
- Converts signed operands to magnitudes, holds operands stable, starts the multiplier, and waits a fixed cycle count.
- Sign-corrects the product, writes the HI/LO registers, and stalls the pipeline on HI/LO access while busy.

Parameters:
- WIDTH, 16, operand width; HI and LO are WIDTH bits each, product is 2*WIDTH bits.
- MUL_CYCLES, 2*WIDTH, cycles from the start cycle until the multiplier product is valid.

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- op_valid  in  1  MULT/MULTU issue request.
- op_signed  in  1  1 = MULT (two's complement), 0 = MULTU.
- op_a  in  WIDTH  operand rs.
- op_b  in  WIDTH  operand rt.
- wr_hi  in  1  MTHI request.
- wr_lo  in  1  MTLO request.
- wr_data  in  WIDTH  MTHI/MTLO data.
- rd_hi  in  1  MFHI request.
- rd_lo  in  1  MFLO request.
- op_ready  out  1  1 when IDLE.
- stall  out  1  pipeline hold.
- done  out  1  one-cycle pulse; HI/LO just updated by a multiply.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- mul_mcand  out  WIDTH  registered multiplicand magnitude to the multiplier.
- mul_mplier  out  WIDTH  registered multiplier magnitude to the multiplier.
- mul_start  out  1  start pulse (Sy) to the multiplier.
- mul_product  in  2*WIDTH  unsigned product from the multiplier.

Behaviour:
- Reset low (async):
  - State goes to IDLE.
  - hi, lo, mul_mcand, mul_mplier and the neg flag go to 0.
  - mul_start, done and stall go to 0; op_ready goes to 1.
  - Reset mid-operation aborts it; HI/LO are not written.
- States: IDLE, START, RUN, FIX.
  - IDLE: op_ready=1.
    - op_valid at edge E: latch mul_mcand=|op_a|, mul_mplier=|op_b| (magnitudes only when op_signed=1, else raw).
    - Same edge: neg = op_signed & (op_a[MSB]^op_b[MSB]); go to START.
  - START: mul_start=1 for exactly this cycle; load counter = MUL_CYCLES-1; go to RUN.
  - RUN: counter decrements each edge; leave for FIX on the edge where counter==0. RUN lasts MUL_CYCLES cycles.
  - FIX: sample mul_product; P = neg ? (~mul_product+1) mod 2^(2*WIDTH) : mul_product.
    - At the FIX exit edge: {hi,lo} <= P, done <= 1 for one cycle, go to IDLE.
- Latency: op accepted at edge E; new hi/lo and done visible from edge E+MUL_CYCLES+2 (34 with defaults).
- Magnitude rule: the most-negative operand (0x8000) maps to 2^(WIDTH-1), which fits WIDTH bits unsigned.
- mul_mcand and mul_mplier are held constant from acceptance until the next acceptance.
- Multiplier contract: mul_product is valid by the FIX cycle and stable throughout it.
- Busy = state != IDLE. stall = busy & (op_valid | rd_hi | rd_lo | wr_hi | wr_lo), combinational.
  - Stalled requests are not consumed; the pipeline holds them until stall drops.
  - Stall drops in the cycle done is high; hi/lo are already updated then.
- In IDLE, MTHI/MTLO write at the edge: wr_hi -> hi, wr_lo -> lo. Both may be asserted in the same cycle.
- Simultaneous op_valid and wr_* in IDLE: the write is performed and the multiply is accepted; the multiply result later overwrites HI/LO.
- rd_hi/rd_lo in IDLE: no stall; hi/lo are continuously driven.
- op_valid during done cycle: accepted normally (state is IDLE), allowing back-to-back issue.

Test Plan:
- Unsigned: MULTU a=0x0003, b=0x0005 -> after 34 edges done=1, hi=0x0000, lo=0x000F; mul_start high exactly 1 cycle.
- Signed mixed: MULT a=0xFFFD (-3), b=0x0007 -> mul_mcand=0x0003, neg=1; result hi=0xFFFF, lo=0xFFEB.
- Corners:
  - MULT 0x8000*0x8000 -> hi=0x4000, lo=0x0000.
  - MULTU 0xFFFF*0xFFFF -> hi=0xFFFE, lo=0x0001.
- Hazard: MFHI asserted 5 cycles after issue -> stall=1 until the done cycle; hi reads the new value when stall falls. A second op_valid while busy is stalled, then accepted in the done cycle.
- MTHI/MTLO: in IDLE, wr_hi=1 and wr_lo=1, wr_data=0x1234 -> hi=lo=0x1234 next edge, no stall. While busy -> stall=1, no write.
- Reset: assert Reset=0 at RUN cycle 10 of 0x0002*0x0003 -> immediately IDLE, hi=lo=0, done never pulses. A fresh op after release completes correctly.
